dm_access_requester: RTL and testbench

//  Core-side initiator for the shared data-memory port. Queues core load/store

---
 rtl/dm_pkg.sv | 30 +++
 rtl/dm_req_fifo.sv | 76 +++++++
 rtl/dm_access_requester.sv | 167 ++++++++++++++++
 tb/tb_dm_access_requester.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared constants and types for the data-memory access requester.
// Status encodings of the arbiter grant, FSM states and the queued request record.
package dm_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    // Arbiter grant encodings; 2'b11 is also treated as blocked.
    localparam logic [1:0] ST_WR_GRANT = 2'b00;
    localparam logic [1:0] ST_BLOCK    = 2'b01;
    localparam logic [1:0] ST_RD_GRANT = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } dm_state_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dm_req_t;

    // A store completes only on a write grant, a load only on a read grant.
    function automatic logic grant_matches(input logic wr, input logic [1:0] status);
        return wr ? (status == ST_WR_GRANT) : (status == ST_RD_GRANT);
    endfunction

endpackage

// File: rtl/dm_req_fifo.sv
// dm_req_fifo: synchronous request queue of {wr, addr, wdata} records.
// Wrap-around pointers, registered full/empty flags, and a peek at the
// entry behind the head so the requester can issue back-to-back.
module dm_req_fifo
    import dm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  dm_req_t wr_req,
    output dm_req_t head,
    output dm_req_t head_next,
    output logic    empty,
    output logic    full,
    output logic    more_than_one
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    dm_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push_ok;
    logic             pop_ok;

    // A push while full is dropped even when a pop frees a slot in the same cycle.
    assign push_ok       = push && !full;
    assign pop_ok        = pop && !empty;
    assign rd_ptr_inc    = rd_ptr + 1'b1;
    assign head          = mem[rd_ptr];
    assign head_next     = mem[rd_ptr_inc];
    assign more_than_one = (count > CNT_W'(1));

    // Occupancy after this cycle's push/pop
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_next = count - 1'b1;
        end
    end

    // Pointers, occupancy and registered flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr_inc;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CNT_W'(DEPTH));
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        // NOTE: the storage is deliberately not reset; the pointers and flags
        // guarantee no stale entry is ever read, and a reset-free array maps to RAM.
        if (push_ok) mem[wr_ptr] <= wr_req;
    end

endmodule

// File: rtl/dm_access_requester.sv
// dm_access_requester: core-side initiator for the shared data-memory port.
// Queues load/store requests, presents the head to the DM selector, waits for
// the matching arbiter grant, captures read data after RD_LAT cycles and
// returns one in-order response per request.
// Optional build macro MEM_TIMEOUT_EN: drop a head that waits TIMEOUT_CYCLES
// ISSUE cycles without a matching grant and answer it with rsp_err.
module dm_access_requester
    import dm_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int RD_LAT         = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        status,
    input  logic [DATA_W-1:0] com_data_out,
    output logic [ADDR_W-1:0] com_addr,
    output logic [DATA_W-1:0] com_data_in,
    output logic              com_wr_en,
    output logic              rsp_valid,
    output logic              rsp_wr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int LAT_W = $clog2(RD_LAT + 1);

    dm_state_e        state;
    logic             cur_wr;
    logic [LAT_W-1:0] lat_cnt;
    logic             in_issue;
    logic             grant_hit;
    logic             timeout_hit;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_multi;
    dm_req_t          fifo_head;
    dm_req_t          fifo_head_next;
    dm_req_t          load_src;

    dm_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push          (req_valid && req_ready),
        .pop           (grant_hit || timeout_hit),
        .wr_req        ('{wr: req_wr, addr: req_addr, wdata: req_wdata}),
        .head          (fifo_head),
        .head_next     (fifo_head_next),
        .empty         (fifo_empty),
        .full          (fifo_full),
        .more_than_one (fifo_multi)
    );

    assign req_ready = !fifo_full;
    assign busy      = !fifo_empty || (state != IDLE);
    assign in_issue  = (state == ISSUE);
    assign grant_hit = in_issue && grant_matches(cur_wr, status);
    assign com_wr_en = in_issue && cur_wr && (status == ST_WR_GRANT);

    // Next request to present: in ISSUE the head is being popped, so use the one behind it
    always_comb begin
        load_src = fifo_head;
        if (in_issue) load_src = fifo_head_next;
    end

    // Request sequencing FSM with registered selector-side and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            state       <= IDLE;
            cur_wr      <= 1'b0;
            lat_cnt     <= '0;
            com_addr    <= '0;
            com_data_in <= '0;
            rsp_valid   <= 1'b0;
            rsp_wr      <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state       <= ISSUE;
                        com_addr    <= load_src.addr;
                        com_data_in <= load_src.wdata;
                        cur_wr      <= load_src.wr;
                    end
                end
                ISSUE: begin
                    if (grant_hit && !cur_wr) begin
                        lat_cnt <= LAT_W'(RD_LAT);
                        state   <= RD_WAIT;
                    end else if (grant_hit || timeout_hit) begin
                        // Store completion, or a dropped head of either type
                        rsp_valid <= 1'b1;
                        rsp_wr    <= cur_wr;
                        if (fifo_multi) begin
                            com_addr    <= load_src.addr;
                            com_data_in <= load_src.wdata;
                            cur_wr      <= load_src.wr;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RD_WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LAT_W'(1)) begin
                        rsp_rdata <= com_data_out;
                        rsp_valid <= 1'b1;
                        rsp_wr    <= 1'b0;
                        if (!fifo_empty) begin
                            state       <= ISSUE;
                            com_addr    <= load_src.addr;
                            com_data_in <= load_src.wdata;
                            cur_wr      <= load_src.wr;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = in_issue && !grant_hit && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Grant-wait counter: restarts on every grant and every pop, so each head gets a full budget
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt  <= '0;
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= timeout_hit;
            if (in_issue && !grant_hit && !timeout_hit) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
        end
    end
`else
    // Without the timeout a head waits for its grant indefinitely.
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign rsp_err            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_dm_access_requester.sv
// tb_dm_access_requester: directed vector table, multi-cycle corner sequences
// and a randomized phase scored against an in-order memory reference model.
module tb_dm_access_requester;
    import dm_pkg::*;

    localparam int DEPTH   = 4;
    localparam int RD_LAT  = 2;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  status;
    logic [15:0] com_data_out;
    logic [15:0] com_addr;
    logic [15:0] com_data_in;
    logic        com_wr_en;
    logic        rsp_valid;
    logic        rsp_wr;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Bench-side memory device: directed mode drives data_drv, random mode models a DM
    logic        dev_mode;
    logic [15:0] data_drv;
    logic [15:0] dev_mem [8];

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mem_data;
        int          wait_cyc;
        logic [1:0]  wait_status;
        logic        exp_wr;
        logic [15:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [15:0] rdata;
    } exp_t;

    vec_t        vecs [6];
    exp_t        expq [$];
    logic [15:0] ref_mem [8];

    always #5 clk = ~clk;

    assign com_data_out = dev_mode ? dev_mem[com_addr[2:0]] : data_drv;

    always @(posedge clk) begin
        if (dev_mode && com_wr_en) dev_mem[com_addr[2:0]] <= com_data_in;
    end

    dm_access_requester #(
        .DEPTH          (DEPTH),
        .RD_LAT         (RD_LAT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .status       (status),
        .com_data_out (com_data_out),
        .com_addr     (com_addr),
        .com_data_in  (com_data_in),
        .com_wr_en    (com_wr_en),
        .rsp_valid    (rsp_valid),
        .rsp_wr       (rsp_wr),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request through push, optional wait with a non-matching status, grant and response
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag       = $sformatf("vec%0d", idx);
        status    = ST_BLOCK;
        req_valid = 1'b1;
        req_wr    = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        step();
        req_valid = 1'b0;
        check({tag, " busy after push"}, busy, 1);
        step();
        for (int c = 0; c < v.wait_cyc; c++) begin
            status = v.wait_status;
            #1;
            check({tag, " addr while waiting"}, com_addr, v.addr);
            check({tag, " wr_en while waiting"}, com_wr_en, 0);
            check({tag, " no rsp while waiting"}, rsp_valid, 0);
            step();
        end
        status = v.wr ? ST_WR_GRANT : ST_RD_GRANT;
        #1;
        check({tag, " addr at grant"}, com_addr, v.addr);
        check({tag, " wdata at grant"}, com_data_in, v.wdata);
        check({tag, " wr_en at grant"}, com_wr_en, v.wr);
        step();
        status = ST_BLOCK;
        if (!v.wr) begin
            for (int k = 1; k <= RD_LAT; k++) begin
                if (k == RD_LAT) data_drv = v.mem_data;
                check({tag, " no rsp during read latency"}, rsp_valid, 0);
                step();
            end
            data_drv = 16'hDEAD;
        end
        status = ST_WR_GRANT;
        #1;
        check({tag, " rsp_valid"}, rsp_valid, 1);
        check({tag, " rsp_wr"}, rsp_wr, v.exp_wr);
        check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, " rsp_err"}, rsp_err, 0);
        check({tag, " wr_en one cycle only"}, com_wr_en, 0);
        step();
        status = ST_BLOCK;
        check({tag, " rsp is a pulse"}, rsp_valid, 0);
        check({tag, " idle after rsp"}, busy, 0);
        check({tag, " addr held in idle"}, com_addr, v.addr);
    endtask

    // Score one registered response against the reference queue
    task automatic monitor_rsp();
        exp_t e;
        if (rsp_valid) begin
            if (expq.size() == 0) begin
                check("rand unexpected rsp", 1, 0);
            end else begin
                e = expq.pop_front();
                check("rand rsp_wr", rsp_wr, e.wr);
                check("rand rsp_err", rsp_err, 0);
                if (!e.wr) check("rand rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    endtask

    int since_wr = 0;
    int since_rd = 0;

    // Random grant that never leaves either grant type absent for more than a few cycles
    task automatic pick_status();
        int s;
        s = $urandom_range(0, 3);
        if (since_wr >= 3)      s = 0;
        else if (since_rd >= 3) s = 2;
        status   = 2'(s);
        since_wr = (s == 0) ? 0 : since_wr + 1;
        since_rd = (s == 2) ? 0 : since_rd + 1;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        status    = ST_BLOCK;
        dev_mode  = 1'b0;
        data_drv  = 16'hDEAD;
        for (int i = 0; i < 8; i++) begin
            dev_mem[i] = '0;
            ref_mem[i] = '0;
        end

        // ---- reset state ----
        step();
        step();
        check("reset req_ready", req_ready, 1);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset busy", busy, 0);
        check("reset com_addr", com_addr, 0);
        check("reset com_data_in", com_data_in, 0);
        check("reset com_wr_en", com_wr_en, 0);
        check("reset rsp_rdata", rsp_rdata, 0);
        check("reset rsp_wr", rsp_wr, 0);
        check("reset rsp_err", rsp_err, 0);
        reset = 1'b0;
        step();

        // ---- vector table ----
        vecs[0] = '{1'b1, 16'h0010, 16'h1234, 16'h0000, 0, ST_BLOCK,    1'b1, 16'h0000};
        vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0, ST_BLOCK,    1'b0, 16'hBEEF};
        vecs[2] = '{1'b1, 16'h00A5, 16'h5A5A, 16'h0000, 5, ST_RD_GRANT, 1'b1, 16'hBEEF};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0001, 3, ST_WR_GRANT, 1'b0, 16'h0001};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1, 2'b11,       1'b0, 16'hFFFF};
        vecs[5] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 2, 2'b11,       1'b1, 16'hFFFF};
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // ---- FIFO full: 4 stores held off, fifth push while full, then back-to-back grants ----
        status = ST_BLOCK;
        for (int i = 0; i < DEPTH; i++) begin
            req_valid = 1'b1;
            req_wr    = 1'b1;
            req_addr  = 16'h0100 + 16'(i);
            req_wdata = 16'hC000 + 16'(i);
            #1;
            check("full: ready before full", req_ready, 1);
            step();
        end
        check("full: ready low when full", req_ready, 0);
        req_addr  = 16'h0BAD;
        req_wdata = 16'h0BAD;
        status    = ST_WR_GRANT;
        #1;
        check("full: first store addr", com_addr, 16'h0100);
        check("full: first store wr_en", com_wr_en, 1);
        step();
        req_valid = 1'b0;
        check("full: ready after pop", req_ready, 1);
        for (int i = 1; i < DEPTH; i++) begin
            check("full: store rsp_valid", rsp_valid, 1);
            check("full: store rsp_wr", rsp_wr, 1);
            check("full: in-order addr", com_addr, 16'h0100 + 16'(i));
            check("full: in-order wdata", com_data_in, 16'hC000 + 16'(i));
            check("full: back-to-back wr_en", com_wr_en, 1);
            step();
        end
        check("full: last rsp_valid", rsp_valid, 1);
        check("full: no fifth write", com_wr_en, 0);
        check("full: fifth push dropped", busy, 0);
        step();
        check("full: exactly four rsps", rsp_valid, 0);
        status = ST_BLOCK;

        // ---- reset during RD_WAIT ----
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 16'h0020;
        step();
        req_valid = 1'b0;
        step();
        status = ST_RD_GRANT;
        step();
        status = ST_BLOCK;
        check("rst-load: busy in RD_WAIT", busy, 1);
        reset = 1'b1;
        step();
        reset    = 1'b0;
        data_drv = 16'h7777;
        check("rst-load: no rsp", rsp_valid, 0);
        check("rst-load: busy cleared", busy, 0);
        check("rst-load: ready", req_ready, 1);
        check("rst-load: com_addr cleared", com_addr, 0);
        check("rst-load: rdata cleared", rsp_rdata, 0);
        for (int i = 0; i < RD_LAT + 2; i++) begin
            step();
            check("rst-load: read discarded", rsp_valid, 0);
        end
        data_drv = 16'hDEAD;

`ifdef MEM_TIMEOUT_EN
        // ---- timeout: blocked store dropped, queued load then completes ----
        status    = ST_BLOCK;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 16'h0300;
        req_wdata = 16'h1111;
        step();
        req_wr    = 1'b0;
        req_addr  = 16'h0301;
        step();
        req_valid = 1'b0;
        for (int c = 0; c < TIMEOUT; c++) begin
            check("timeout: waiting head", com_addr, 16'h0300);
            check("timeout: no early rsp", rsp_valid, 0);
            step();
        end
        check("timeout: rsp_valid", rsp_valid, 1);
        check("timeout: rsp_err", rsp_err, 1);
        check("timeout: rsp_wr is head type", rsp_wr, 1);
        check("timeout: rdata unchanged", rsp_rdata, 0);
        status = ST_RD_GRANT;
        #1;
        check("timeout: next head presented", com_addr, 16'h0301);
        step();
        status = ST_BLOCK;
        check("timeout: err is a pulse", rsp_err, 0);
        for (int k = 1; k <= RD_LAT; k++) begin
            if (k == RD_LAT) data_drv = 16'hABCD;
            step();
        end
        data_drv = 16'hDEAD;
        check("timeout: next load rsp", rsp_valid, 1);
        check("timeout: next load no err", rsp_err, 0);
        check("timeout: next load data", rsp_rdata, 16'hABCD);
        step();
`endif

        // ---- randomized traffic against the in-order memory model ----
        status   = ST_BLOCK;
        dev_mode = 1'b1;
        step();
        for (int c = 0; c < 800; c++) begin
            monitor_rsp();
            req_valid = ($urandom_range(0, 3) != 0);
            req_wr    = 1'($urandom_range(0, 1));
            req_addr  = 16'($urandom);
            req_wdata = 16'($urandom);
            pick_status();
            #1;
            check("rand wr_en only on write grant", com_wr_en && (status != ST_WR_GRANT), 0);
            if (req_valid && req_ready) begin
                if (req_wr) begin
                    ref_mem[req_addr[2:0]] = req_wdata;
                    expq.push_back('{1'b1, 16'h0000});
                end else begin
                    expq.push_back('{1'b0, ref_mem[req_addr[2:0]]});
                end
            end
            step();
        end
        req_valid = 1'b0;
        begin
            bit drained;
            drained = 1'b0;
            for (int c = 0; c < 400 && !drained; c++) begin
                monitor_rsp();
                if (expq.size() == 0 && !busy && !rsp_valid) begin
                    drained = 1'b1;
                end else begin
                    pick_status();
                    step();
                end
            end
            check("rand drain within budget", drained, 1);
            check("rand all responses seen", expq.size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
